// File: rtl/seg7_mux_driver.sv
// seg7_mux_driver: time-multiplexed driver for a common-anode, two-digit
// seven-segment display. It cycles GUARD_A -> ONES -> GUARD_B -> TENS, with an
// all-off guard interval before each digit slot to suppress ghosting. Both
// digits are snapshotted once per frame, on entry to ONES, so a frame never
// shows a torn value.
// Optional feature macro: SEG7_BRIGHTNESS_EN adds a 3-bit brightness input
// that shortens the lit part of each digit slot to (brightness+1)/8 of it.
module seg7_mux_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] ones_in,
  input  logic [3:0] tens_in,
`ifdef SEG7_BRIGHTNESS_EN
  input  logic [2:0] brightness,
`endif
  output logic [6:0] seg_n,
  output logic [1:0] an_n,
  output logic       dp_n,
  output logic       frame_tick
);

  localparam int MAX_LEN = (REFRESH_DIV > GUARD) ? REFRESH_DIV : GUARD;
  localparam int CW      = $clog2(MAX_LEN);

  localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST   = CW'(GUARD - 1);

  localparam logic [6:0] SEG_OFF   = 7'h7F;
  localparam logic [1:0] AN_OFF    = 2'b11;
  localparam logic [3:0] BLANK     = 4'hF;

  typedef enum logic [1:0] {
    S_GUARD_A = 2'd0,
    S_ONES    = 2'd1,
    S_GUARD_B = 2'd2,
    S_TENS    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    ones_snap_q, ones_snap_d;
  logic [3:0]    tens_snap_q, tens_snap_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;
  logic          tick_q, tick_d;
  logic          entering_ones;
  logic          slot_lit;

`ifdef SEG7_BRIGHTNESS_EN
  logic [2:0]    bright_q, bright_d;
`endif

  // Active-low segment pattern {g,f,e,d,c,b,a}; A-E show a dash, F is blank.
  function automatic logic [6:0] decode(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'h0:    pattern = 7'h40;
      4'h1:    pattern = 7'h79;
      4'h2:    pattern = 7'h24;
      4'h3:    pattern = 7'h30;
      4'h4:    pattern = 7'h19;
      4'h5:    pattern = 7'h12;
      4'h6:    pattern = 7'h02;
      4'h7:    pattern = 7'h78;
      4'h8:    pattern = 7'h00;
      4'h9:    pattern = 7'h10;
      4'hF:    pattern = 7'h7F;
      default: pattern = 7'h3F;
    endcase
    return pattern;
  endfunction

  // Slot sequencing: each state holds until its counter reaches length-1,
  // and the counter restarts from zero on every state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    case (state_q)
      S_GUARD_A: if (cnt_q == GUARD_LAST)   state_d = S_ONES;
      S_ONES:    if (cnt_q == REFRESH_LAST) state_d = S_GUARD_B;
      S_GUARD_B: if (cnt_q == GUARD_LAST)   state_d = S_TENS;
      S_TENS:    if (cnt_q == REFRESH_LAST) state_d = S_GUARD_A;
      default:                              state_d = S_GUARD_A;
    endcase
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  // Capture both digits (and brightness) only on the edge entering ONES.
  always_comb begin
    entering_ones = (state_q == S_GUARD_A) && (state_d == S_ONES);
    ones_snap_d   = ones_snap_q;
    tens_snap_d   = tens_snap_q;
`ifdef SEG7_BRIGHTNESS_EN
    bright_d      = bright_q;
`endif
    if (entering_ones) begin
      ones_snap_d = ones_in;
      tens_snap_d = tens_in;
`ifdef SEG7_BRIGHTNESS_EN
      bright_d    = brightness;
`endif
    end
  end

  // Decide whether the digit is lit at the slot position the next cycle shows.
`ifdef SEG7_BRIGHTNESS_EN
  always_comb begin
    slot_lit = (32'(cnt_d) < (32'(bright_d) + 32'd1) * 32'(REFRESH_DIV / 8));
  end
`else
  assign slot_lit = 1'b1;
`endif

  // Outputs are computed from the upcoming state so they change on the same
  // edge as the state itself.
  always_comb begin
    seg_d  = SEG_OFF;
    an_d   = AN_OFF;
    tick_d = entering_ones;
    case (state_d)
      S_ONES: begin
        if ((ones_snap_d != BLANK) && slot_lit) begin
          an_d  = 2'b10;
          seg_d = decode(ones_snap_d);
        end
      end
      S_TENS: begin
        if ((tens_snap_d != BLANK) && slot_lit) begin
          an_d  = 2'b01;
          seg_d = decode(tens_snap_d);
        end
      end
      default: begin
        seg_d = SEG_OFF;
        an_d  = AN_OFF;
      end
    endcase
  end

  // State, counter, snapshot and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_GUARD_A;
      cnt_q       <= '0;
      ones_snap_q <= BLANK;
      tens_snap_q <= BLANK;
`ifdef SEG7_BRIGHTNESS_EN
      bright_q    <= 3'd7;
`endif
      seg_q       <= SEG_OFF;
      an_q        <= AN_OFF;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ones_snap_q <= ones_snap_d;
      tens_snap_q <= tens_snap_d;
`ifdef SEG7_BRIGHTNESS_EN
      bright_q    <= bright_d;
`endif
      seg_q       <= seg_d;
      an_q        <= an_d;
      tick_q      <= tick_d;
    end
  end

  assign seg_n      = seg_q;
  assign an_n       = an_q;
  assign frame_tick = tick_q;
  assign dp_n       = 1'b1;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// tb_seg7_mux_driver: drives seg7_mux_driver with directed and random digit
// streams and resets, and compares every cycle against a frame-position model
// (position = cycles since reset modulo the frame length).
module tb_seg7_mux_driver;

  localparam int R     = 8;
  localparam int G     = 2;
  localparam int FRAME = 2 * (G + R);

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] onesIn = 4'h0;
  logic [3:0] tensIn = 4'h0;
`ifdef SEG7_BRIGHTNESS_EN
  logic [2:0] brightness = 3'd7;
  logic [2:0] snapBright = 3'd7;
`endif
  logic [6:0] segN;
  logic [1:0] anN;
  logic       dpN;
  logic       frameTick;

  int testsRun    = 0;
  int testsFailed = 0;
  int cycle       = 0;
  int t           = 0;
  logic [3:0] snapOnes = 4'hF;
  logic [3:0] snapTens = 4'hF;

  seg7_mux_driver #(.REFRESH_DIV(R), .GUARD(G)) dut (
    .clock      (clock),
    .reset      (reset),
    .ones_in    (onesIn),
    .tens_in    (tensIn),
`ifdef SEG7_BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .seg_n      (segN),
    .an_n       (anN),
    .dp_n       (dpN),
    .frame_tick (frameTick)
  );

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  // Reference segment patterns for the decimal digits, active-low {g..a}.
  function automatic logic [6:0] refDecode(input logic [3:0] d);
    logic [6:0] digitTable [10];
    digitTable = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                   7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    if (d < 4'd10) return digitTable[d];
    if (d == 4'hF) return 7'h7F;
    return 7'h3F;
  endfunction

  // Counts one comparison and reports it when it does not hold.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h",
               tag, cycle, actual, expected);
    end
  endtask

  // Expected outputs from the position within the current frame.
  task automatic computeExpected(output logic [6:0] seg, output logic [1:0] an,
                                 output logic tick);
    int p, s, limit;
    logic [3:0] digit;
    logic inDigit, isTens;
    p = t % FRAME;
    seg = 7'h7F;
    an = 2'b11;
    tick = 1'b0;
    inDigit = 1'b0;
    isTens = 1'b0;
    s = 0;
    if (p >= G && p < G + R) begin
      inDigit = 1'b1;
      s = p - G;
      tick = (s == 0);
    end else if (p >= 2 * G + R) begin
      inDigit = 1'b1;
      isTens = 1'b1;
      s = p - 2 * G - R;
    end
`ifdef SEG7_BRIGHTNESS_EN
    limit = (int'(snapBright) + 1) * R / 8;
`else
    limit = R;
`endif
    if (inDigit) begin
      digit = isTens ? snapTens : snapOnes;
      if (digit != 4'hF && s < limit) begin
        seg = refDecode(digit);
        an = isTens ? 2'b01 : 2'b10;
      end
    end
  endtask

  // Drives one cycle of inputs, advances the model at the edge and compares.
  task automatic applyStimulus(input logic rst, input logic [3:0] ones,
                               input logic [3:0] tens, input logic [2:0] br);
    logic [6:0] expSeg;
    logic [1:0] expAn;
    logic expTick;
    @(negedge clock);
    reset = rst;
    onesIn = ones;
    tensIn = tens;
`ifdef SEG7_BRIGHTNESS_EN
    brightness = br;
`endif
    @(posedge clock);
    cycle++;
    if (reset) begin
      t = 0;
      snapOnes = 4'hF;
      snapTens = 4'hF;
`ifdef SEG7_BRIGHTNESS_EN
      snapBright = 3'd7;
`endif
    end else begin
      t++;
      if (t % FRAME == G) begin
        snapOnes = onesIn;
        snapTens = tensIn;
`ifdef SEG7_BRIGHTNESS_EN
        snapBright = brightness;
`endif
      end
    end
    #1;
    computeExpected(expSeg, expAn, expTick);
    checkOutput("seg_n", 32'(segN), 32'(expSeg));
    checkOutput("an_n", 32'(anN), 32'(expAn));
    checkOutput("frame_tick", 32'(frameTick), 32'(expTick));
    checkOutput("dp_n", 32'(dpN), 32'd1);
  endtask

  initial begin
    logic [3:0] ones, tens;
    logic [2:0] br;

    // Hold reset for a few cycles.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'h2, 4'h4, 3'd7);

    // Tens 4, ones 2 for two frames, first at low brightness then full.
    for (int i = 0; i < FRAME; i++) applyStimulus(1'b0, 4'h2, 4'h4, 3'd1);
    for (int i = 0; i < FRAME; i++) applyStimulus(1'b0, 4'h2, 4'h4, 3'd7);

    // Blank tens with ones 7, restarted from reset.
    applyStimulus(1'b1, 4'h7, 4'hF, 3'd7);
    for (int i = 0; i < 2 * FRAME; i++) applyStimulus(1'b0, 4'h7, 4'hF, 3'd7);

    // Ones 3 then 9 arriving mid-TENS, followed by a reset in the middle of ONES.
    for (int i = 0; i < FRAME; i++)
      applyStimulus(1'b0, (t % FRAME >= 2 * G + R) ? 4'h9 : 4'h3, 4'h1, 3'd7);
    for (int i = 0; i < FRAME + G + 3; i++) applyStimulus(1'b0, 4'h9, 4'h1, 3'd7);
    applyStimulus(1'b1, 4'h9, 4'h1, 3'd7);
    for (int i = 0; i < FRAME; i++) applyStimulus(1'b0, 4'h5, 4'h6, 3'd7);

    // Random digits, brightness and occasional resets at arbitrary points.
    ones = 4'h0;
    tens = 4'h0;
    br = 3'd7;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) ones = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) tens = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) br = 3'($urandom_range(0, 7));
      applyStimulus($urandom_range(0, 149) == 0, ones, tens, br);
    end

    // Sweep every input code through both digits.
    for (int v = 0; v < 16; v++)
      for (int i = 0; i < 2 * FRAME; i++)
        applyStimulus(1'b0, 4'(v), 4'(15 - v), 3'd7);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
